// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Loads hit with zero latency; misses refill a whole line word by word
// over a single-word req/ack bus. Stores always go to the bus and update
// the cached copy only when the line is present.
module dcache_wt #(
   parameter int XLEN       = 32,
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic [XLEN-1:0] cpu_wdata,
   input  logic [3:0]      cpu_byte_en,
   input  logic            cpu_rd_en,
   input  logic            cpu_wr_en,
   output logic [XLEN-1:0] cpu_rdata,
   output logic            cpu_ready,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_byte_en,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_ack
);

   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(NUM_LINES);
   localparam int TW = XLEN - IB - WB - 2;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [WB-1:0]         cnt;
   logic [NUM_LINES-1:0]  valid;
   logic [TW-1:0]         tag_mem  [NUM_LINES];
   logic [XLEN-1:0]       data_mem [NUM_LINES*LINE_WORDS];

   logic [WB-1:0]         req_word;
   logic [IB-1:0]         req_index;
   logic [TW-1:0]         req_tag;
   logic [IB+WB-1:0]      word_idx;
   logic [IB+WB-1:0]      fill_idx;
   logic                  hit;
   logic                  is_wr;
   logic                  is_rd;
   logic                  rd_miss;
   logic                  bus_active;
   logic                  ack_ok;
   logic                  last_word;
   logic                  unused_addr_bits;

   // Merge the enabled byte lanes of a store into an existing word.
   function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_w,
                                                   input logic [XLEN-1:0] new_w,
                                                   input logic [3:0]      be);
      logic [XLEN-1:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   assign req_word         = cpu_addr[WB+1:2];
   assign req_index        = cpu_addr[IB+WB+1:WB+2];
   assign req_tag          = cpu_addr[XLEN-1:IB+WB+2];
   assign word_idx         = {req_index, req_word};
   assign fill_idx         = {req_index, cnt};
   assign unused_addr_bits = ^cpu_addr[1:0];

   // A simultaneous read and write strobe is treated as a write.
   assign is_wr     = cpu_wr_en;
   assign is_rd     = cpu_rd_en & ~cpu_wr_en;
   assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);
   assign rd_miss   = is_rd & ~hit;
   assign last_word = (cnt == WB'(LINE_WORDS - 1));

   // The bus is owned only in FILL/WRITE and is released while reset is held;
   // an ack without an outstanding request is ignored.
   assign bus_active = ~reset & ((state == FILL) || (state == WRITE));
   assign ack_ok     = bus_ack & bus_active;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (is_wr)        state_nxt = WRITE;
            else if (rd_miss) state_nxt = FILL;
         end
         FILL:  if (ack_ok && last_word) state_nxt = IDLE;
         WRITE: if (ack_ok)              state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-state CPU and bus outputs; bus request depends on state, never on ack.
   always_comb begin
      cpu_ready   = 1'b0;
      cpu_rdata   = '0;
      bus_req     = bus_active;
      bus_we      = 1'b0;
      bus_addr    = '0;
      bus_wdata   = '0;
      bus_byte_en = 4'h0;
      case (state)
         IDLE: begin
            cpu_ready = ~reset & ~is_wr & ~rd_miss;
            if (is_rd && hit) cpu_rdata = data_mem[word_idx];
         end
         FILL: begin
            bus_addr    = {cpu_addr[XLEN-1:WB+2], cnt, 2'b00};
            bus_byte_en = 4'hF;
         end
         WRITE: begin
            bus_we      = 1'b1;
            bus_addr    = {cpu_addr[XLEN-1:2], 2'b00};
            bus_wdata   = cpu_wdata;
            bus_byte_en = cpu_byte_en;
            cpu_ready   = ack_ok;
         end
         default: ;
      endcase
   end

   // Fill counter and valid bits; a line is invalidated when its refill starts
   // so an interrupted fill can never produce a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_miss) begin
                  cnt              <= '0;
                  valid[req_index] <= 1'b0;
               end
            end
            FILL: begin
               if (ack_ok) begin
                  cnt <= cnt + WB'(1);
                  if (last_word) valid[req_index] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag array, written once the final word of a refill lands.
   always_ff @(posedge clk) begin
      if (state == FILL && ack_ok && last_word) tag_mem[req_index] <= req_tag;
   end

   // Data array: refill words, or byte-merge a store that hits.
   always_ff @(posedge clk) begin
      if (state == FILL && ack_ok)
         data_mem[fill_idx] <= bus_rdata;
      else if (state == WRITE && ack_ok && hit)
         data_mem[word_idx] <= merge_bytes(data_mem[word_idx], cpu_wdata, cpu_byte_en);
   end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: a bus responder that acks one cycle after
// each request, backed by a sparse memory, plus hand-computed expectations.
module tb_dcache_wt;

   localparam int LIMIT = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_byte_en;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_byte_en;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int checks = 0;
   int errors = 0;

   logic [31:0] log_addr  [$];
   logic        log_we    [$];
   logic [3:0]  log_be    [$];
   logic [31:0] log_wdata [$];
   logic [31:0] mem_w [logic [31:0]];
   logic        pend;

   dcache_wt dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_byte_en (cpu_byte_en),
      .cpu_rd_en   (cpu_rd_en),
      .cpu_wr_en   (cpu_wr_en),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_byte_en (bus_byte_en),
      .bus_rdata   (bus_rdata),
      .bus_ack     (bus_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Untouched memory words hold {addr[15:0]^16'h5A5A, addr[15:0]}.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_w.exists(a)) return mem_w[a];
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // Bus responder: ack arrives in the cycle after the request first appears.
   initial begin
      bus_ack   = 1'b0;
      bus_rdata = '0;
      pend      = 1'b0;
      forever begin
         @(negedge clk);
         bus_ack   = 1'b0;
         bus_rdata = '0;
         if (bus_req) begin
            if (pend) begin
               logic [31:0] w;
               bus_ack = 1'b1;
               if (bus_we) begin
                  w = mem_rd(bus_addr);
                  for (int b = 0; b < 4; b++)
                     if (bus_byte_en[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
                  mem_w[bus_addr] = w;
               end else begin
                  bus_rdata = mem_rd(bus_addr);
               end
               log_addr.push_back(bus_addr);
               log_we.push_back(bus_we);
               log_be.push_back(bus_byte_en);
               log_wdata.push_back(bus_wdata);
               pend = 1'b0;
            end else begin
               pend = 1'b1;
            end
         end else begin
            pend = 1'b0;
         end
      end
   end

   task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                          output int stall, output int nb);
      int base;
      base      = log_addr.size();
      cpu_addr  = a;
      cpu_rd_en = 1'b1;
      cpu_wr_en = 1'b0;
      stall     = 0;
      #1;
      while (!cpu_ready && stall < LIMIT) begin
         stall++;
         @(negedge clk); #1;
      end
      check("rd_timeout", 32'(stall >= LIMIT), 32'd0);
      d = cpu_rdata;
      @(negedge clk); #1;
      cpu_rd_en = 1'b0;
      nb = log_addr.size() - base;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           output int stall, output int nb);
      int base;
      base        = log_addr.size();
      cpu_addr    = a;
      cpu_wdata   = wd;
      cpu_byte_en = be;
      cpu_wr_en   = 1'b1;
      stall       = 0;
      #1;
      while (!cpu_ready && stall < LIMIT) begin
         stall++;
         @(negedge clk); #1;
      end
      check("wr_timeout", 32'(stall >= LIMIT), 32'd0);
      @(negedge clk); #1;
      cpu_wr_en   = 1'b0;
      cpu_byte_en = 4'h0;
      cpu_wdata   = '0;
      nb = log_addr.size() - base;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int st, nb, base, n;

      reset = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = 4'h0;
      cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", cpu_ready, 0);
      check("rst_busreq", bus_req, 0);
      cpu_rd_en = 1'b1; cpu_addr = 32'h100; #1;
      check("rst_ready_rd", cpu_ready, 0);
      check("rst_busreq_rd", bus_req, 0);
      cpu_rd_en = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0; #1;
      check("idle_ready", cpu_ready, 1);
      check("idle_rdata", cpu_rdata, 0);
      check("idle_busaddr", bus_addr, 0);

      // Cold miss on 0x100
      base = log_addr.size();
      do_read(32'h100, d, st, nb);
      check("t1_rdata", d, 32'h5B5A0100);
      check("t1_stall", st, 9);
      check("t1_nbus", nb, 4);
      for (int i = 0; i < 4; i++) begin
         check("t1_addr", log_addr[base+i], 32'h100 + 32'(4*i));
         check("t1_we", 32'(log_we[base+i]), 0);
         check("t1_be", 32'(log_be[base+i]), 32'hF);
      end

      // Zero-latency hit
      do_read(32'h108, d, st, nb);
      check("t2_rdata", d, 32'h5B520108);
      check("t2_stall", st, 0);
      check("t2_nbus", nb, 0);

      // Store hit with a single byte lane
      base = log_addr.size();
      do_write(32'h104, 32'h0000AB00, 4'b0010, st, nb);
      check("t3_stall", st, 2);
      check("t3_nbus", nb, 1);
      check("t3_addr", log_addr[base], 32'h104);
      check("t3_we", 32'(log_we[base]), 1);
      check("t3_be", 32'(log_be[base]), 32'h2);
      check("t3_wdata", log_wdata[base], 32'h0000AB00);
      do_read(32'h104, d, st, nb);
      check("t3_merge", d, 32'h5B5EAB04);
      check("t3_rd_stall", st, 0);
      check("t3_rd_nbus", nb, 0);

      // Store miss: no allocate, later read refills
      base = log_addr.size();
      do_write(32'h2000, 32'h11223344, 4'hF, st, nb);
      check("t4_stall", st, 2);
      check("t4_nbus", nb, 1);
      check("t4_we", 32'(log_we[base]), 1);
      base = log_addr.size();
      do_read(32'h2000, d, st, nb);
      check("t4_rdata", d, 32'h11223344);
      check("t4_rd_stall", st, 9);
      check("t4_rd_nbus", nb, 4);
      for (int i = 0; i < 4; i++)
         check("t4_addr", log_addr[base+i], 32'h2000 + 32'(4*i));
      do_read(32'h2004, d, st, nb);
      check("t4_hit2", d, 32'h7A5E2004);
      check("t4_hit2_stall", st, 0);

      // Conflict eviction on index 0x10
      base = log_addr.size();
      do_read(32'h500, d, st, nb);
      check("t5_rdata", d, 32'h5F5A0500);
      check("t5_stall", st, 9);
      check("t5_addr0", log_addr[base], 32'h500);
      do_read(32'h100, d, st, nb);
      check("t5_refill", d, 32'h5B5A0100);
      check("t5_re_stall", st, 9);
      check("t5_re_nbus", nb, 4);
      do_read(32'h104, d, st, nb);
      check("t5_wt_data", d, 32'h5B5EAB04);
      check("t5_wt_stall", st, 0);

      // Reset in the middle of a refill
      do_read(32'h500, d, st, nb);
      check("t6_evict_stall", st, 9);
      base = log_addr.size();
      cpu_addr = 32'h100; cpu_rd_en = 1'b1;
      n = 0;
      while (log_addr.size() < base + 2 && n < LIMIT) begin
         @(negedge clk); #1;
         n++;
      end
      check("t6_wait_timeout", 32'(n >= LIMIT), 0);
      @(negedge clk); #1;
      reset = 1'b1; cpu_rd_en = 1'b0; #1;
      check("t6_rst_busreq", bus_req, 0);
      check("t6_rst_ready", cpu_ready, 0);
      @(negedge clk); #1;
      check("t6_rst_busreq2", bus_req, 0);
      check("t6_partial_acks", log_addr.size() - base, 2);
      reset = 1'b0; #1;
      check("t6_idle_ready", cpu_ready, 1);
      check("t6_idle_busreq", bus_req, 0);
      base = log_addr.size();
      do_read(32'h100, d, st, nb);
      check("t6_rdata", d, 32'h5B5A0100);
      check("t6_stall", st, 9);
      check("t6_nbus", nb, 4);
      check("t6_addr0", log_addr[base], 32'h100);
      do_read(32'h500, d, st, nb);
      check("t6_500_stall", st, 9);
      check("t6_500_rdata", d, 32'h5F5A0500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
